// File: rtl/umi_remap_pkg.sv
// umi_remap_pkg: shared constants, buffer states and chip-ID lookup
// used by the UMI address remap and unmap blocks.
package umi_remap_pkg;

  localparam int ID_W   = 16;
  localparam int ID_SB  = 40;
  localparam int N_MAPS = 8;
  localparam int IDX_W  = $clog2(N_MAPS);

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } id_match_t;

  // Priority match of id against a packed table; lowest index wins.
  function automatic id_match_t id_lookup(
    input logic [ID_W-1:0]        id,
    input logic [ID_W*N_MAPS-1:0] tbl
  );
    id_match_t m;
    m = '0;
    for (int i = N_MAPS - 1; i >= 0; i--) begin
      if (tbl[i*ID_W +: ID_W] == id) begin
        m.hit = 1'b1;
        m.idx = IDX_W'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/umi_skid_buffer.sv
// umi_skid_buffer: two-entry registered valid/ready stage.
// Ports: clk, reset, in_valid/in_data/in_ready, out_valid/out_data/out_ready.
module umi_skid_buffer
  import umi_remap_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  buf_state_t   state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         full_q;
  logic         accept;
  logic         drain;

  // Ready comes from the registered full flag only; reset just masks it.
  assign in_ready = !full_q && !reset;
  assign out_data = main_q;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BUF_EMPTY;
      out_valid <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      unique case (state)
        BUF_EMPTY: begin
          if (accept) begin
            main_q    <= in_data;
            out_valid <= 1'b1;
            state     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && drain) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q <= in_data;
            full_q <= 1'b1;
            state  <= BUF_FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (drain) begin
            main_q <= skid_q;
            full_q <= 1'b0;
            state  <= BUF_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          full_q    <= 1'b0;
          state     <= BUF_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/umi_address_unmap.sv
// umi_address_unmap: restores remapped chip IDs in srcaddr and removes
// the dstaddr window offset, then registers packets in a skid stage.
// Ports: clk/reset, chipid, ID map tables, window low/high/offset,
// umi_in_* packet (valid/ready), umi_out_* packet (valid/ready), stat_hits.
module umi_address_unmap
  import umi_remap_pkg::*;
#(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 256,
  parameter int IDW   = ID_W,
  parameter int IDSB  = ID_SB,
  parameter int NMAPS = N_MAPS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDW-1:0]       chipid,
  input  logic [IDW*NMAPS-1:0] old_row_col_address,
  input  logic [IDW*NMAPS-1:0] new_row_col_address,
  input  logic [AW-1:0]        set_dstaddress_low,
  input  logic [AW-1:0]        set_dstaddress_high,
  input  logic [AW-1:0]        set_dstaddress_offset,
  input  logic                 umi_in_valid,
  input  logic [CW-1:0]        umi_in_cmd,
  input  logic [AW-1:0]        umi_in_dstaddr,
  input  logic [AW-1:0]        umi_in_srcaddr,
  input  logic [DW-1:0]        umi_in_data,
  output logic                 umi_in_ready,
  output logic                 umi_out_valid,
  output logic [CW-1:0]        umi_out_cmd,
  output logic [AW-1:0]        umi_out_dstaddr,
  output logic [AW-1:0]        umi_out_srcaddr,
  output logic [DW-1:0]        umi_out_data,
  input  logic                 umi_out_ready,
  output logic [31:0]          stat_hits
);

  localparam int PW = CW + 2*AW + DW;

  logic [IDW-1:0] fld;
  id_match_t      m;
  logic           id_hit;
  logic           win_hit;
  logic [IDW-1:0] old_id;
  logic [AW-1:0]  src_x;
  logic [AW-1:0]  dst_x;
  logic [PW-1:0]  pkt_x;
  logic [PW-1:0]  pkt_q;

  assign fld    = umi_in_srcaddr[IDSB+IDW-1:IDSB];
  assign m      = id_lookup(fld, new_row_col_address);
  assign id_hit = m.hit && (fld != chipid);
  assign old_id = old_row_col_address[int'(m.idx)*IDW +: IDW];

  always_comb begin
    src_x = umi_in_srcaddr;
    if (id_hit) begin
      src_x[IDSB +: IDW] = old_id;
    end
  end

  assign win_hit = (umi_in_dstaddr >= set_dstaddress_low) &&
                   (umi_in_dstaddr <= set_dstaddress_high);
  // Subtraction wraps modulo 2^AW by construction.
  assign dst_x   = win_hit ? umi_in_dstaddr - set_dstaddress_offset
                           : umi_in_dstaddr;

  assign pkt_x = {umi_in_cmd, dst_x, src_x, umi_in_data};

  umi_skid_buffer #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (umi_in_valid),
    .in_data   (pkt_x),
    .in_ready  (umi_in_ready),
    .out_valid (umi_out_valid),
    .out_data  (pkt_q),
    .out_ready (umi_out_ready)
  );

  assign {umi_out_cmd, umi_out_dstaddr,
          umi_out_srcaddr, umi_out_data} = pkt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits <= '0;
    end else if (umi_in_valid && umi_in_ready &&
                 (id_hit || win_hit) &&
                 (stat_hits != 32'hFFFF_FFFF)) begin
      stat_hits <= stat_hits + 32'd1;
    end
  end

endmodule

// File: tb/tb_umi_address_unmap.sv
// tb_umi_address_unmap: directed and random checks of the unmap block
// against a reference model and an in-order scoreboard.
module tb_umi_address_unmap;

  localparam logic [15:0] CHIP = 16'h0004;
  localparam logic [63:0] LOW  = 64'h0000_0600_0000_0000;
  localparam logic [63:0] HIGH = 64'h0000_06FF_FFFF_FF7F;
  localparam logic [63:0] OFF  = 64'hFFFF_FFFF_FFFF_FF80;

  typedef struct packed {
    logic [31:0]  cmd;
    logic [63:0]  dst;
    logic [63:0]  src;
    logic [255:0] data;
  } pkt_t;

  logic         clk;
  logic         reset;
  logic [15:0]  chipid;
  logic [127:0] old_map;
  logic [127:0] new_map;
  logic [63:0]  win_low;
  logic [63:0]  win_high;
  logic [63:0]  win_off;
  logic         umi_in_valid;
  logic [31:0]  umi_in_cmd;
  logic [63:0]  umi_in_dstaddr;
  logic [63:0]  umi_in_srcaddr;
  logic [255:0] umi_in_data;
  logic         umi_in_ready;
  logic         umi_out_valid;
  logic [31:0]  umi_out_cmd;
  logic [63:0]  umi_out_dstaddr;
  logic [63:0]  umi_out_srcaddr;
  logic [255:0] umi_out_data;
  logic         umi_out_ready;
  logic [31:0]  stat_hits;

  umi_address_unmap dut (
    .clk                   (clk),
    .reset                 (reset),
    .chipid                (chipid),
    .old_row_col_address   (old_map),
    .new_row_col_address   (new_map),
    .set_dstaddress_low    (win_low),
    .set_dstaddress_high   (win_high),
    .set_dstaddress_offset (win_off),
    .umi_in_valid          (umi_in_valid),
    .umi_in_cmd            (umi_in_cmd),
    .umi_in_dstaddr        (umi_in_dstaddr),
    .umi_in_srcaddr        (umi_in_srcaddr),
    .umi_in_data           (umi_in_data),
    .umi_in_ready          (umi_in_ready),
    .umi_out_valid         (umi_out_valid),
    .umi_out_cmd           (umi_out_cmd),
    .umi_out_dstaddr       (umi_out_dstaddr),
    .umi_out_srcaddr       (umi_out_srcaddr),
    .umi_out_data          (umi_out_data),
    .umi_out_ready         (umi_out_ready),
    .stat_hits             (stat_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests;
  int          fails;
  int          cyc;
  int          n_in;
  int          n_out;
  int          first_in_cyc;
  int          first_out_cyc;
  int          last_out_cyc;
  logic [31:0] exp_hits;
  pkt_t        q[$];

  task automatic check(input string tag,
                       input logic [415:0] got,
                       input logic [415:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic pkt_t model(input pkt_t p, output bit hit);
    pkt_t        r;
    logic [15:0] f;
    bit          idh;
    bit          wh;
    r   = p;
    f   = p.src[55:40];
    idh = 1'b0;
    wh  = 1'b0;
    if (f != CHIP) begin
      for (int i = 0; i < 8; i++) begin
        if (!idh && f == ~16'(i)) begin
          idh = 1'b1;
          r.src[55:40] = 16'(i);
        end
      end
    end
    if (p.dst >= LOW && p.dst <= HIGH) begin
      wh    = 1'b1;
      r.dst = p.dst - OFF;
    end
    hit = idh || wh;
    return r;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.cmd = $urandom;
    p.dst = {$urandom, $urandom};
    p.src = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) p.data[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0: p.src[55:40] = ~16'($urandom_range(0, 7));
      1: p.src[55:40] = CHIP;
      default: ;
    endcase
    case ($urandom_range(0, 5))
      0: p.dst = LOW;
      1: p.dst = HIGH;
      2: p.dst = HIGH + 64'd1;
      3: p.dst = LOW - 64'd1;
      4: p.dst = LOW + {40'h0, p.dst[23:0]};
      default: ;
    endcase
    return p;
  endfunction

  function automatic pkt_t mk(input logic [63:0] src,
                              input logic [63:0] dst);
    pkt_t p;
    p      = rand_pkt();
    p.src  = src;
    p.dst  = dst;
    return p;
  endfunction

  task automatic drive(input pkt_t p);
    umi_in_valid   = 1'b1;
    umi_in_cmd     = p.cmd;
    umi_in_dstaddr = p.dst;
    umi_in_srcaddr = p.src;
    umi_in_data    = p.data;
  endtask

  // Scoreboard work at the falling edge, ahead of the next rising edge.
  task automatic sample();
    pkt_t o;
    pkt_t e;
    bit   h;
    check("stat_hits", 416'(stat_hits), 416'(exp_hits));
    if (umi_out_valid) begin
      o = {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_out: got %0h want none", o);
      end
      if (q.size() != 0) begin
        check("out_pkt", o, q[0]);
        if (umi_out_ready) begin
          void'(q.pop_front());
          n_out++;
          if (first_out_cyc < 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
        end
      end
    end
    if (umi_in_valid && umi_in_ready) begin
      e = model({umi_in_cmd, umi_in_dstaddr,
                 umi_in_srcaddr, umi_in_data}, h);
      q.push_back(e);
      n_in++;
      if (first_in_cyc < 0) first_in_cyc = cyc;
      if (h && exp_hits != 32'hFFFF_FFFF) exp_hits++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    tick();
  endtask

  task automatic directed(input string tag, input pkt_t p,
                          input logic [63:0] want_src,
                          input logic [63:0] want_dst,
                          input logic [31:0] want_hits);
    umi_out_ready = 1'b1;
    drive(p);
    step();
    umi_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 416'(umi_out_valid), 416'(1'b1));
    check({tag, "_src"}, 416'(umi_out_srcaddr), 416'(want_src));
    check({tag, "_dst"}, 416'(umi_out_dstaddr), 416'(want_dst));
    check({tag, "_hits"}, 416'(stat_hits), 416'(want_hits));
    sample();
    tick();
  endtask

  initial begin
    int base_in;
    int base_out;
    int guard;
    int k;
    pkt_t bp[3];

    tests = 0; fails = 0; cyc = 0; n_in = 0; n_out = 0;
    exp_hits = '0;
    first_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    chipid   = CHIP;
    win_low  = LOW;
    win_high = HIGH;
    win_off  = OFF;
    for (int i = 0; i < 8; i++) begin
      old_map[i*16 +: 16] = 16'(i);
      new_map[i*16 +: 16] = ~16'(i);
    end
    reset          = 1'b1;
    umi_in_valid   = 1'b0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_in_ready", 416'(umi_in_ready), 416'(1'b0));
    check("rst_out_valid", 416'(umi_out_valid), 416'(1'b0));
    check("rst_hits", 416'(stat_hits), 416'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 416'(umi_in_ready), 416'(1'b1));
    check("post_rst_valid", 416'(umi_out_valid), 416'(1'b0));
    sample();
    tick();

    // Directed translation cases
    directed("id_hit", mk(64'h00FF_FD00_0000_1000, 64'h100),
             64'h0000_0200_0000_1000, 64'h100, 32'd1);
    directed("local_id", mk(64'h0000_0400_0000_0000, 64'h100),
             64'h0000_0400_0000_0000, 64'h100, 32'd1);
    directed("win_in", mk(64'h0012_3400_0000_0000, LOW),
             64'h0012_3400_0000_0000, 64'h0000_0600_0000_0080, 32'd2);
    directed("win_out", mk(64'h0012_3400_0000_0000,
                           64'h0000_0700_0000_0000),
             64'h0012_3400_0000_0000, 64'h0000_0700_0000_0000, 32'd2);
    directed("win_high", mk(64'h0012_3400_0000_0000, HIGH),
             64'h0012_3400_0000_0000, 64'h0000_06FF_FFFF_FFFF, 32'd3);
    directed("win_above", mk(64'h0012_3400_0000_0000,
                             64'h0000_06FF_FFFF_FF80),
             64'h0012_3400_0000_0000, 64'h0000_06FF_FFFF_FF80, 32'd3);
    directed("win_below", mk(64'h0012_3400_0000_0000,
                             64'h0000_05FF_FFFF_FFFF),
             64'h0012_3400_0000_0000, 64'h0000_05FF_FFFF_FFFF, 32'd3);
    directed("both_hit", mk(64'h00FF_F800_0000_0000, LOW),
             64'h0000_0700_0000_0000, 64'h0000_0600_0000_0080, 32'd4);

    // Backpressure: three offered, two accepted
    umi_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) bp[i] = rand_pkt();
    base_in  = n_in;
    base_out = n_out;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      drive(bp[k]);
      step();
      if (n_in - base_in > k) k++;
    end
    check("bp_accepted", 416'(n_in - base_in), 416'(2));
    umi_in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready", 416'(umi_in_ready), 416'(1'b0));
    sample();
    tick();
    step();
    step();
    umi_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("bp_drained", 416'(n_out - base_out), 416'(2));
    check("bp_q_empty", 416'(q.size()), 416'(0));

    // Throughput and latency
    base_in  = n_in;
    base_out = n_out;
    first_in_cyc  = -1;
    first_out_cyc = -1;
    last_out_cyc  = -1;
    umi_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(rand_pkt());
      step();
    end
    umi_in_valid = 1'b0;
    step();
    step();
    check("tp_in", 416'(n_in - base_in), 416'(100));
    check("tp_out", 416'(n_out - base_out), 416'(100));
    check("tp_first", 416'(first_out_cyc), 416'(first_in_cyc + 1));
    check("tp_last", 416'(last_out_cyc), 416'(first_in_cyc + 100));

    // Random valid/ready
    base_in = n_in;
    guard   = 0;
    while ((n_in - base_in) < 10000 && guard < 60000) begin
      if ($urandom_range(0, 3) != 0) drive(rand_pkt());
      else umi_in_valid = 1'b0;
      umi_out_ready = ($urandom_range(0, 2) != 0);
      step();
      guard++;
    end
    check("rnd_count", 416'(n_in - base_in), 416'(10000));
    umi_in_valid  = 1'b0;
    umi_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rnd_q_empty", 416'(q.size()), 416'(0));

    // Reset while full
    umi_out_ready = 1'b0;
    drive(rand_pkt());
    step();
    drive(rand_pkt());
    step();
    @(negedge clk);
    check("mid_full", 416'(umi_in_ready), 416'(1'b0));
    sample();
    drive(rand_pkt());
    reset = 1'b1;
    tick();
    q.delete();
    exp_hits = '0;
    reset = 1'b0;
    umi_in_valid  = 1'b0;
    umi_out_ready = 1'b1;
    base_out = n_out;
    @(negedge clk);
    check("mid_rst_valid", 416'(umi_out_valid), 416'(1'b0));
    check("mid_rst_hits", 416'(stat_hits), 416'(0));
    check("mid_rst_ready", 416'(umi_in_ready), 416'(1'b1));
    sample();
    tick();
    for (int i = 0; i < 3; i++) step();
    check("mid_rst_stale", 416'(n_out - base_out), 416'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
